// File: rtl/hpdcache_l15_req_arbiter_rt.sv
// Round-robin arbiter of N requesters onto the L1.5 request channel, with a per-ID
// routing table that steers each response back to the port that issued it.
module hpdcache_l15_req_arbiter_rt #(
  parameter int unsigned N = 2,
  parameter type req_t = logic,
  parameter type id_t = logic,
  parameter type req_portid_t = logic,
  localparam int unsigned RT_DEPTH = 2 ** $bits(id_t),
  localparam int unsigned CNT_W = $clog2(RT_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_valid_i,
  output logic [N-1:0]         req_ready_o,
  input  req_t [N-1:0]         req_i,
  input  id_t  [N-1:0]         req_id_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output req_t                 mem_req_o,
  output id_t                  mem_req_id_o,
  input  logic                 mem_resp_valid_i,
  input  logic                 mem_resp_ready_i,
  input  id_t                  mem_resp_id_i,
  output req_portid_t          mem_resp_sel_o,
  output logic [CNT_W-1:0]     outstanding_o,
  output logic                 error_o
);

  localparam int unsigned PTR_W = $clog2(N);
  typedef logic [PTR_W-1:0] ptr_t;

  logic [RT_DEPTH-1:0] rt_busy_q;
  req_portid_t         rt_port_q [RT_DEPTH];
  ptr_t                rr_ptr_q;
  logic                lock_q;
  ptr_t                lock_port_q;
  logic [CNT_W-1:0]    outstanding_q;
  logic                error_q;

  logic [N-1:0] elig;
  logic         rr_found;
  ptr_t         rr_win;
  ptr_t         cand;
  ptr_t         win;
  logic         grant;
  logic         alloc;
  logic         resp_hs;
  logic         free_ok;

  // Busy comes straight from the register, so an entry freed this cycle is only
  // eligible for re-allocation from the next cycle on.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = req_valid_i[i] && !rt_busy_q[req_id_i[i]];
    end
  end

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_t'((int'(rr_ptr_q) + k) % int'(N));
      if (!rr_found && elig[cand]) begin
        rr_found = 1'b1;
        rr_win   = cand;
      end
    end
  end

  // A stalled grant is held on its port so valid/payload stay stable on the L1.5 channel.
  assign win     = lock_q ? lock_port_q : rr_win;
  assign grant   = lock_q ? elig[lock_port_q] : rr_found;
  assign alloc   = grant && mem_req_ready_i;
  assign resp_hs = mem_resp_valid_i && mem_resp_ready_i;
  assign free_ok = resp_hs && rt_busy_q[mem_resp_id_i];

  // Channel outputs are forced low while reset is asserted.
  assign mem_req_valid_o = rst_ni && grant;
  assign mem_req_o       = rst_ni ? req_i[win] : '0;
  assign mem_req_id_o    = rst_ni ? req_id_i[win] : '0;
  assign mem_resp_sel_o  = rt_port_q[mem_resp_id_i];
  assign outstanding_o   = outstanding_q;
  assign error_o         = error_q;

  always_comb begin
    req_ready_o = '0;
    if (rst_ni && grant) req_ready_o[win] = mem_req_ready_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rt_busy_q     <= '0;
      // NOTE: the table is small and its port fields drive mem_resp_sel_o, so it is reset rather than left as uninitialised RAM.
      for (int i = 0; i < RT_DEPTH; i++) rt_port_q[i] <= '0;
      rr_ptr_q      <= '0;
      lock_q        <= 1'b0;
      lock_port_q   <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
    end else begin
      error_q <= resp_hs && !rt_busy_q[mem_resp_id_i];

      // Alloc needs a non-busy ID and free needs a busy one, so they never hit the same entry.
      if (free_ok) rt_busy_q[mem_resp_id_i] <= 1'b0;
      if (alloc) begin
        rt_busy_q[req_id_i[win]] <= 1'b1;
        rt_port_q[req_id_i[win]] <= req_portid_t'(win);
        rr_ptr_q                 <= (win == ptr_t'(N - 1)) ? '0 : win + ptr_t'(1);
        lock_q                   <= 1'b0;
      end else if (grant) begin
        lock_q      <= 1'b1;
        lock_port_q <= win;
      end

      unique case ({alloc, free_ok})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

endmodule

// File: tb/tb_hpdcache_l15_req_arbiter_rt.sv
// Directed bench for the L1.5 request arbiter / routing table, N=4 ports, 4-bit IDs.
module tb_hpdcache_l15_req_arbiter_rt;

  localparam int N = 4;
  typedef logic [7:0] req_t;
  typedef logic [3:0] id_t;
  typedef logic [1:0] pid_t;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [N-1:0]     req_valid_i;
  logic [N-1:0]     req_ready_o;
  req_t [N-1:0]     req_i;
  id_t  [N-1:0]     req_id_i;
  logic             mem_req_valid_o;
  logic             mem_req_ready_i;
  req_t             mem_req_o;
  id_t              mem_req_id_o;
  logic             mem_resp_valid_i;
  logic             mem_resp_ready_i;
  id_t              mem_resp_id_i;
  pid_t             mem_resp_sel_o;
  logic [4:0]       outstanding_o;
  logic             error_o;

  int checks = 0;
  int failures = 0;

  hpdcache_l15_req_arbiter_rt #(
    .N(N), .req_t(req_t), .id_t(id_t), .req_portid_t(pid_t)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_i(req_i), .req_id_i(req_id_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_o(mem_req_o), .mem_req_id_o(mem_req_id_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_i(mem_resp_ready_i),
    .mem_resp_id_i(mem_resp_id_i), .mem_resp_sel_o(mem_resp_sel_o),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then changed and
  // outputs checked 1ns later, well before the following edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input id_t id);
    req_valid_i[p] = v;
    req_id_i[p]    = id;
    req_i[p]       = req_t'(8'hA0 + p);
  endtask

  task automatic check_grant(input string tag, input id_t id, input logic [3:0] rdy);
    check({tag, "_valid"}, 32'(mem_req_valid_o), 32'd1);
    check({tag, "_id"}, 32'(mem_req_id_o), 32'(id));
    check({tag, "_ready"}, 32'(req_ready_o), 32'(rdy));
  endtask

  initial begin
    rst_ni           = 1'b0;
    req_valid_i      = '0;
    req_i            = '0;
    req_id_i         = '0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_ready_i = 1'b0;
    mem_resp_id_i    = '0;

    // Reset: outputs low even with requests presented.
    tick();
    for (int p = 0; p < N; p++) set_port(p, 1'b1, id_t'(p));
    mem_req_ready_i = 1'b1;
    settle();
    check("rst_mem_req_valid", 32'(mem_req_valid_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_req_id", 32'(mem_req_id_o), 32'd0);
    check("rst_outstanding", 32'(outstanding_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    check("rst_resp_sel", 32'(mem_resp_sel_o), 32'd0);

    // 1: round-robin grants 0,1,2,3; each winner's ID then reads busy.
    tick();
    rst_ni = 1'b1;
    settle();
    check_grant("t1_g0", 4'd0, 4'b0001);
    check("t1_g0_payload", 32'(mem_req_o), 32'hA0);
    tick();
    check_grant("t1_g1", 4'd1, 4'b0010);
    check("t1_g1_payload", 32'(mem_req_o), 32'hA1);
    tick();
    check_grant("t1_g2", 4'd2, 4'b0100);
    tick();
    check_grant("t1_g3", 4'd3, 4'b1000);
    check("t1_g3_payload", 32'(mem_req_o), 32'hA3);
    tick();
    check("t1_all_busy_valid", 32'(mem_req_valid_o), 32'd0);
    check("t1_outstanding", 32'(outstanding_o), 32'd4);
    req_valid_i = '0;

    // 2: response for ID 2 routed to port 2 and freed.
    mem_resp_valid_i = 1'b1;
    mem_resp_ready_i = 1'b1;
    mem_resp_id_i    = 4'd2;
    settle();
    check("t2_resp_sel", 32'(mem_resp_sel_o), 32'd2);
    tick();
    mem_resp_valid_i = 1'b0;
    settle();
    check("t2_outstanding", 32'(outstanding_o), 32'd3);

    // 3: port 1 stalled with ready low; port 0 raises valid but the lock holds.
    mem_req_ready_i = 1'b0;
    set_port(1, 1'b1, 4'd4);
    settle();
    check_grant("t3_c0", 4'd4, 4'b0000);
    tick();
    set_port(0, 1'b1, 4'd6);
    settle();
    check_grant("t3_c1", 4'd4, 4'b0000);
    check("t3_c1_payload", 32'(mem_req_o), 32'hA1);
    tick();
    check_grant("t3_c2", 4'd4, 4'b0000);
    tick();
    mem_req_ready_i = 1'b1;
    settle();
    check_grant("t3_hs1", 4'd4, 4'b0010);
    tick();
    req_valid_i[1] = 1'b0;
    settle();
    check_grant("t3_hs0", 4'd6, 4'b0001);
    tick();
    req_valid_i[0] = 1'b0;
    settle();
    check("t3_outstanding", 32'(outstanding_o), 32'd5);

    // 4: port 2 waits on busy ID 5 until the response frees it.
    set_port(3, 1'b1, 4'd5);
    settle();
    check_grant("t4_alloc5", 4'd5, 4'b1000);
    tick();
    req_valid_i[3] = 1'b0;
    set_port(2, 1'b1, 4'd5);
    settle();
    check("t4_blocked0", 32'(mem_req_valid_o), 32'd0);
    tick();
    check("t4_blocked1", 32'(mem_req_valid_o), 32'd0);
    check("t4_outstanding_pre", 32'(outstanding_o), 32'd6);
    mem_resp_valid_i = 1'b1;
    mem_resp_id_i    = 4'd5;
    settle();
    check("t4_free_cycle_valid", 32'(mem_req_valid_o), 32'd0);
    check("t4_resp_sel", 32'(mem_resp_sel_o), 32'd3);
    tick();
    mem_resp_valid_i = 1'b0;
    settle();
    check_grant("t4_accept", 4'd5, 4'b0100);
    check("t4_outstanding_mid", 32'(outstanding_o), 32'd5);
    tick();
    req_valid_i[2] = 1'b0;
    settle();
    check("t4_outstanding_post", 32'(outstanding_o), 32'd6);
    check("t4_no_error", 32'(error_o), 32'd0);

    // 5: response for never-allocated ID 9 -> one-cycle error pulse.
    mem_resp_valid_i = 1'b1;
    mem_resp_id_i    = 4'd9;
    tick();
    mem_resp_valid_i = 1'b0;
    settle();
    check("t5_error_pulse", 32'(error_o), 32'd1);
    check("t5_outstanding", 32'(outstanding_o), 32'd6);
    tick();
    check("t5_error_clear", 32'(error_o), 32'd0);

    // 6: free ID 3, allocate ID 7 on port 1, then alloc 3 + free 7 together.
    mem_resp_valid_i = 1'b1;
    mem_resp_id_i    = 4'd3;
    settle();
    check("t6_resp_sel3", 32'(mem_resp_sel_o), 32'd3);
    tick();
    mem_resp_valid_i = 1'b0;
    set_port(1, 1'b1, 4'd7);
    settle();
    check_grant("t6_alloc7", 4'd7, 4'b0010);
    check("t6_outstanding_a", 32'(outstanding_o), 32'd5);
    tick();
    req_valid_i[1] = 1'b0;
    set_port(0, 1'b1, 4'd3);
    mem_resp_valid_i = 1'b1;
    mem_resp_id_i    = 4'd7;
    settle();
    check("t6_outstanding_b", 32'(outstanding_o), 32'd6);
    check_grant("t6_alloc3", 4'd3, 4'b0001);
    check("t6_resp_sel7", 32'(mem_resp_sel_o), 32'd1);
    tick();
    req_valid_i[0] = 1'b0;
    mem_resp_valid_i = 1'b0;
    set_port(2, 1'b1, 4'd3);
    settle();
    check("t6_outstanding_c", 32'(outstanding_o), 32'd6);
    check("t6_id3_busy", 32'(mem_req_valid_o), 32'd0);

    // Reset mid-stream: ID 3 is busy and requested; reset clears everything.
    rst_ni = 1'b0;
    mem_resp_valid_i = 1'b1;
    settle();
    check("t6_rst_valid", 32'(mem_req_valid_o), 32'd0);
    check("t6_rst_ready", 32'(req_ready_o), 32'd0);
    check("t6_rst_outstanding", 32'(outstanding_o), 32'd0);
    check("t6_rst_sel", 32'(mem_resp_sel_o), 32'd0);
    check("t6_rst_error", 32'(error_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    req_valid_i = '0;
    settle();
    check("t6_post_rst_valid", 32'(mem_req_valid_o), 32'd0);
    tick();
    mem_resp_valid_i = 1'b0;
    settle();
    check("t6_late_resp_error", 32'(error_o), 32'd1);
    check("t6_late_outstanding", 32'(outstanding_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
